// File: rtl/sdrc_req_arb_if.sv
// rtl/sdrc_req_arb_if.sv - SDRAM controller request/data port shared by the arbiter
interface sdrc_req_arb_if #(
    parameter int AW = 26,
    parameter int LW = 9,
    parameter int DW = 32
);
    logic              sdr_req;
    logic [AW-1:0]     sdr_req_addr;
    logic [LW-1:0]     sdr_req_len;
    logic              sdr_req_wr_n;
    logic              sdr_req_ack;
    logic              sdr_busy_n;
    logic              sdr_wr_next;
    logic [DW-1:0]     sdr_wr_data;
    logic [DW/8-1:0]   sdr_wr_en_n;
    logic              sdr_rd_valid;
    logic              sdr_last_rd;
    logic [DW-1:0]     sdr_rd_data;

    modport master (
        output sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n,
        output sdr_wr_data, sdr_wr_en_n,
        input  sdr_req_ack, sdr_busy_n, sdr_wr_next,
        input  sdr_rd_valid, sdr_last_rd, sdr_rd_data
    );

    modport slave (
        input  sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n,
        input  sdr_wr_data, sdr_wr_en_n,
        output sdr_req_ack, sdr_busy_n, sdr_wr_next,
        output sdr_rd_valid, sdr_last_rd, sdr_rd_data
    );
endinterface

// File: rtl/sdrc_req_arb.sv
// rtl/sdrc_req_arb.sv - round-robin arbiter and transfer sequencer for the SDRAM controller port
module sdrc_req_arb #(
    parameter int NREQ = 2,
    parameter int AW   = 26,
    parameter int LW   = 9,
    parameter int DW   = 32
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_resetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*LW-1:0]     req_len,
    input  logic [NREQ-1:0]        req_wr_n,
    input  logic [NREQ*DW-1:0]     req_wr_data,
    input  logic [NREQ*DW/8-1:0]   req_wr_en_n,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        req_wr_next,
    output logic [NREQ-1:0]        req_rd_valid,
    output logic [NREQ-1:0]        req_last_rd,
    output logic [DW-1:0]          req_rd_data,
    output logic [NREQ-1:0]        gnt,
    sdrc_req_arb_if.master         sdr
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, REQ, WR, RD} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_q, gnt_nxt;
    logic [SW-1:0]   ptr_q, ptr_nxt;
    logic            sdr_req_q, sdr_req_nxt;
    logic [AW-1:0]   addr_q, addr_nxt;
    logic [LW-1:0]   len_q, len_nxt;
    logic            wr_n_q, wr_n_nxt;
    logic [LW-1:0]   beat_q, beat_nxt;

    logic            found;
    logic [SW-1:0]   pick;

    // Search starts just past the last winner, so the requester served most
    // recently is considered last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                pick  = SW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            state     <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= SW'(NREQ - 1);
            sdr_req_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wr_n_q    <= 1'b1;
            beat_q    <= '0;
        end else begin
            state     <= state_nxt;
            gnt_q     <= gnt_nxt;
            ptr_q     <= ptr_nxt;
            sdr_req_q <= sdr_req_nxt;
            addr_q    <= addr_nxt;
            len_q     <= len_nxt;
            wr_n_q    <= wr_n_nxt;
            beat_q    <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_q;
        ptr_nxt     = ptr_q;
        sdr_req_nxt = sdr_req_q;
        addr_nxt    = addr_q;
        len_nxt     = len_q;
        wr_n_nxt    = wr_n_q;
        beat_nxt    = beat_q;
        case (state)
            IDLE: begin
                if (found && sdr.sdr_busy_n) begin
                    gnt_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    ptr_nxt     = pick;
                    addr_nxt    = req_addr[int'(pick)*AW +: AW];
                    len_nxt     = req_len[int'(pick)*LW +: LW];
                    wr_n_nxt    = req_wr_n[pick];
                    sdr_req_nxt = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (sdr.sdr_req_ack) begin
                    sdr_req_nxt = 1'b0;
                    beat_nxt    = '0;
                    if (len_q == '0) begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (!wr_n_q) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                if (sdr.sdr_wr_next) begin
                    beat_nxt = beat_q + LW'(1);
                    if (beat_q == len_q - LW'(1)) begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            RD: begin
                if (sdr.sdr_rd_valid && sdr.sdr_last_rd) begin
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Routed strobes reuse the one-hot grant as the steering mask.
    always_comb begin
        req_ack          = '0;
        req_wr_next      = '0;
        req_rd_valid     = '0;
        req_last_rd      = '0;
        sdr.sdr_wr_data  = '0;
        sdr.sdr_wr_en_n  = '1;
        if (state == REQ && sdr.sdr_req_ack) begin
            req_ack = gnt_q;
        end
        if (state == WR) begin
            sdr.sdr_wr_data = req_wr_data[int'(ptr_q)*DW +: DW];
            sdr.sdr_wr_en_n = req_wr_en_n[int'(ptr_q)*BW +: BW];
            if (sdr.sdr_wr_next) begin
                req_wr_next = gnt_q;
            end
        end
        if (state == RD) begin
            if (sdr.sdr_rd_valid) begin
                req_rd_valid = gnt_q;
            end
            if (sdr.sdr_last_rd) begin
                req_last_rd = gnt_q;
            end
        end
    end

    assign req_rd_data      = sdr.sdr_rd_data;
    assign gnt              = gnt_q;
    assign sdr.sdr_req      = sdr_req_q;
    assign sdr.sdr_req_addr = addr_q;
    assign sdr.sdr_req_len  = len_q;
    assign sdr.sdr_req_wr_n = wr_n_q;
endmodule

// File: tb/tb_sdrc_req_arb.sv
// tb/tb_sdrc_req_arb.sv - self-checking bench for sdrc_req_arb
module tb_sdrc_req_arb;
    localparam int NREQ = 2;
    localparam int AW   = 26;
    localparam int LW   = 9;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*LW-1:0]   req_len;
    logic [NREQ-1:0]      req_wr_n;
    logic [NREQ*DW-1:0]   req_wr_data;
    logic [NREQ*BW-1:0]   req_wr_en_n;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_wr_next;
    logic [NREQ-1:0]      req_rd_valid;
    logic [NREQ-1:0]      req_last_rd;
    logic [DW-1:0]        req_rd_data;
    logic [NREQ-1:0]      gnt;

    sdrc_req_arb_if #(.AW(AW), .LW(LW), .DW(DW)) sif ();

    sdrc_req_arb #(.NREQ(NREQ), .AW(AW), .LW(LW), .DW(DW)) dut (
        .sdram_clk    (clk),
        .sdram_resetn (resetn),
        .req          (req),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_wr_n     (req_wr_n),
        .req_wr_data  (req_wr_data),
        .req_wr_en_n  (req_wr_en_n),
        .req_ack      (req_ack),
        .req_wr_next  (req_wr_next),
        .req_rd_valid (req_rd_valid),
        .req_last_rd  (req_last_rd),
        .req_rd_data  (req_rd_data),
        .gnt          (gnt),
        .sdr          (sif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr;
    logic [AW-1:0] f_addr [NREQ];
    logic [LW-1:0] f_len  [NREQ];
    logic          f_wr_n [NREQ];

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin reference: first pending requester after the last one served.
    function automatic int predict();
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic arm(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
        f_addr[i] = a;
        f_len[i]  = l;
        f_wr_n[i] = w;
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
        req_wr_n[i]          = w;
        req[i]               = 1'b1;
    endtask

    task automatic shuffle_wr_data();
        for (int j = 0; j < NREQ; j++) begin
            req_wr_data[j*DW +: DW] = DW'($urandom);
            req_wr_en_n[j*BW +: BW] = BW'($urandom);
        end
    endtask

    // Plays the SDRAM controller for one burst expected to go to requester i.
    task automatic serve(input int i, input int ack_dly, input bit drop, input bit hold);
        int t;
        logic [NREQ-1:0] eg;
        logic [DW-1:0]   rd_word;
        int len;
        t  = 0;
        eg = oh(i);
        while (sif.sdr_req !== 1'b1 && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        n_cmp++;
        if (sif.sdr_req !== 1'b1) begin
            n_bad++;
            $display("FAIL serve_timeout req%0d: sdr_req=%b required 1", i, sif.sdr_req);
            return;
        end
        n_cmp++;
        if (gnt !== eg) begin
            n_bad++;
            $display("FAIL grant: gnt=%b required %b", gnt, eg);
        end
        n_cmp++;
        if ({sif.sdr_req_addr, sif.sdr_req_len, sif.sdr_req_wr_n} !== {f_addr[i], f_len[i], f_wr_n[i]}) begin
            n_bad++;
            $display("FAIL command: addr=%h len=%0d wr_n=%b required addr=%h len=%0d wr_n=%b",
                     sif.sdr_req_addr, sif.sdr_req_len, sif.sdr_req_wr_n, f_addr[i], f_len[i], f_wr_n[i]);
        end
        if (drop) req[i] = 1'b0;
        repeat (ack_dly) begin
            @(negedge clk); #1;
            n_cmp++;
            if (sif.sdr_req !== 1'b1 || req_ack !== '0 || sif.sdr_req_addr !== f_addr[i]) begin
                n_bad++;
                $display("FAIL req_hold: sdr_req=%b req_ack=%b addr=%h required 1/0/%h",
                         sif.sdr_req, req_ack, sif.sdr_req_addr, f_addr[i]);
            end
        end
        sif.sdr_req_ack = 1'b1;
        #1;
        n_cmp++;
        if (req_ack !== eg) begin
            n_bad++;
            $display("FAIL req_ack: req_ack=%b required %b", req_ack, eg);
        end
        if (!hold) req[i] = 1'b0;
        @(negedge clk);
        sif.sdr_req_ack = 1'b0;
        #1;
        model_ptr = i;
        n_cmp++;
        if (sif.sdr_req !== 1'b0 || req_ack !== '0) begin
            n_bad++;
            $display("FAIL after_ack: sdr_req=%b req_ack=%b required 0/0", sif.sdr_req, req_ack);
        end
        len = int'(f_len[i]);
        if (len == 0) begin
            sif.sdr_wr_next = 1'b1;
            #1;
            n_cmp++;
            if (gnt !== '0 || req_wr_next !== '0) begin
                n_bad++;
                $display("FAIL len0_end: gnt=%b req_wr_next=%b required 0/0", gnt, req_wr_next);
            end
            sif.sdr_wr_next = 1'b0;
            return;
        end
        for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(0, 1)) begin
                n_cmp++;
                if (req_wr_next !== '0 || req_rd_valid !== '0 || gnt !== eg) begin
                    n_bad++;
                    $display("FAIL gap: wr_next=%b rd_valid=%b gnt=%b required 0/0/%b",
                             req_wr_next, req_rd_valid, gnt, eg);
                end
                @(negedge clk); #1;
            end
            shuffle_wr_data();
            if (!f_wr_n[i]) begin
                sif.sdr_wr_next  = 1'b1;
                sif.sdr_rd_valid = 1'($urandom_range(0, 1));
                #1;
                n_cmp++;
                if (req_wr_next !== eg || req_rd_valid !== '0 ||
                    sif.sdr_wr_data !== req_wr_data[i*DW +: DW] ||
                    sif.sdr_wr_en_n !== req_wr_en_n[i*BW +: BW]) begin
                    n_bad++;
                    $display("FAIL wr_beat%0d: wr_next=%b rd_valid=%b data=%h en_n=%h required %b/0/%h/%h",
                             b, req_wr_next, req_rd_valid, sif.sdr_wr_data, sif.sdr_wr_en_n,
                             eg, req_wr_data[i*DW +: DW], req_wr_en_n[i*BW +: BW]);
                end
            end else begin
                rd_word          = DW'($urandom);
                sif.sdr_rd_data  = rd_word;
                sif.sdr_rd_valid = 1'b1;
                sif.sdr_last_rd  = (b == len - 1);
                sif.sdr_wr_next  = 1'($urandom_range(0, 1));
                #1;
                n_cmp++;
                if (req_rd_valid !== eg || req_last_rd !== ((b == len - 1) ? eg : '0) ||
                    req_rd_data !== rd_word || req_wr_next !== '0) begin
                    n_bad++;
                    $display("FAIL rd_beat%0d: rd_valid=%b last=%b data=%h wr_next=%b required %b/%b/%h/0",
                             b, req_rd_valid, req_last_rd, req_rd_data, req_wr_next,
                             eg, ((b == len - 1) ? eg : '0), rd_word);
                end
            end
            @(negedge clk);
            sif.sdr_wr_next  = 1'b0;
            sif.sdr_rd_valid = 1'b0;
            sif.sdr_last_rd  = 1'b0;
            #1;
            n_cmp++;
            if (gnt !== ((b == len - 1) ? '0 : eg)) begin
                n_bad++;
                $display("FAIL burst_gnt beat%0d: gnt=%b required %b", b, gnt, ((b == len - 1) ? '0 : eg));
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (gnt !== '0 || sif.sdr_req !== 1'b0 || sif.sdr_req_addr !== '0 ||
            sif.sdr_req_len !== '0 || sif.sdr_req_wr_n !== 1'b1 || req_ack !== '0) begin
            n_bad++;
            $display("FAIL reset_state: gnt=%b sdr_req=%b addr=%h len=%0d wr_n=%b ack=%b required 0/0/0/0/1/0",
                     gnt, sif.sdr_req, sif.sdr_req_addr, sif.sdr_req_len, sif.sdr_req_wr_n, req_ack);
        end
        resetn = 1'b1;
        model_ptr = NREQ - 1;
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 0, 1};
        arm(0, AW'($urandom), LW'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        arm(1, AW'($urandom), LW'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (predict() != order[n]) begin
                n_bad++;
                $display("FAIL rr_model burst%0d: model=%0d required %0d", n, predict(), order[n]);
            end
            serve(order[n], $urandom_range(0, 2), 1'b0, 1'b1);
        end
        req = '0;
    endtask

    task automatic test_single_write();
        arm(0, AW'('h000100), LW'(4), 1'b0);
        @(negedge clk); #1;
        n_cmp++;
        if (sif.sdr_req !== 1'b1 || gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL write_latency: sdr_req=%b gnt=%b required 1/01", sif.sdr_req, gnt);
        end
        serve(0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_single_read();
        arm(1, AW'($urandom), LW'(3), 1'b1);
        serve(1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        sif.sdr_busy_n = 1'b0;
        arm(0, AW'($urandom), LW'(2), 1'b0);
        repeat (5) begin
            @(negedge clk); #1;
            n_cmp++;
            if (sif.sdr_req !== 1'b0 || gnt !== '0) begin
                n_bad++;
                $display("FAIL busy_hold: sdr_req=%b gnt=%b required 0/0", sif.sdr_req, gnt);
            end
        end
        sif.sdr_busy_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (sif.sdr_req !== 1'b1 || gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL busy_release: sdr_req=%b gnt=%b required 1/01", sif.sdr_req, gnt);
        end
        serve(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_len0();
        arm(1, AW'($urandom), LW'(0), 1'b0);
        serve(1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_len511();
        arm(0, AW'($urandom), LW'(511), 1'b0);
        serve(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_drop_req();
        arm(1, AW'($urandom), LW'(3), 1'b1);
        serve(1, 2, 1'b1, 1'b0);
        arm(0, AW'($urandom), LW'(2), 1'b0);
        serve(0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_wr();
        int t;
        arm(0, AW'($urandom), LW'(8), 1'b0);
        t = 0;
        while (sif.sdr_req !== 1'b1 && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        sif.sdr_req_ack = 1'b1;
        req[0] = 1'b0;
        @(negedge clk);
        sif.sdr_req_ack = 1'b0;
        repeat (2) begin
            sif.sdr_wr_next = 1'b1;
            @(negedge clk);
            sif.sdr_wr_next = 1'b0;
        end
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_wr_gnt: gnt=%b required 01", gnt);
        end
        resetn = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (gnt !== '0 || sif.sdr_req !== 1'b0 || req_wr_next !== '0 || sif.sdr_req_wr_n !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_wr_reset: gnt=%b sdr_req=%b wr_next=%b wr_n=%b required 0/0/0/1",
                     gnt, sif.sdr_req, req_wr_next, sif.sdr_req_wr_n);
        end
        resetn = 1'b1;
        model_ptr = NREQ - 1;
        arm(0, AW'($urandom), LW'(1), 1'b1);
        arm(1, AW'($urandom), LW'(1), 1'b0);
        serve(predict(), 0, 1'b0, 1'b0);
        serve(predict(), 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!req[j] && $urandom_range(0, 1) == 1)
                    arm(j, AW'($urandom), LW'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            end
            if (req == '0) begin
                w = $urandom_range(0, NREQ - 1);
                arm(w, AW'($urandom), LW'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            end
            w = predict();
            serve(w, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        req             = '0;
        req_addr        = '0;
        req_len         = '0;
        req_wr_n        = '1;
        req_wr_data     = '0;
        req_wr_en_n     = '1;
        sif.sdr_req_ack  = 1'b0;
        sif.sdr_busy_n   = 1'b1;
        sif.sdr_wr_next  = 1'b0;
        sif.sdr_rd_valid = 1'b0;
        sif.sdr_last_rd  = 1'b0;
        sif.sdr_rd_data  = '0;
        model_ptr       = NREQ - 1;

        test_reset();
        test_round_robin();
        test_single_write();
        test_single_read();
        test_backpressure();
        test_len0();
        test_len511();
        test_drop_req();
        test_reset_mid_wr();
        test_random();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/sdrc_req_arb.md
Name: sdrc_req_arb

Overview:
Round-robin arbiter and transfer sequencer in the sdram_clk domain. It shares the single SDRAM controller request/data port (sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n, sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_last_rd) between NREQ bus bridges such as the Wishbone-to-SDRAM bridge. It grants one requester at a time. It holds the grant through that requester's whole data phase, then re-arbitrates.

Parameters:
NREQ, 2, number of requesters (2..4)
AW, 26, request address width
LW, 9, burst length width (words)
DW, 32, data width; byte-enable width is DW/8

Ports:
sdram_clk  in  1  single clock
sdram_resetn  in  1  synchronous active-low reset
req  in  NREQ  per-requester request, held until its req_ack
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_len  in  NREQ*LW  packed burst lengths
req_wr_n  in  NREQ  0=write, 1=read
req_wr_data  in  NREQ*DW  packed write data
req_wr_en_n  in  NREQ*DW/8  packed active-low byte enables
req_ack  out  NREQ  one-cycle accept pulse to granted requester
req_wr_next  out  NREQ  write-data pop, routed to granted requester
req_rd_valid  out  NREQ  read data valid, routed to granted requester
req_last_rd  out  NREQ  last read word, routed to granted requester
req_rd_data  out  DW  read data broadcast to all requesters
gnt  out  NREQ  one-hot current grant
sdr_req  out  1  request to controller
sdr_req_addr  out  AW  registered address
sdr_req_len  out  LW  registered length
sdr_req_wr_n  out  1  registered direction
sdr_req_ack  in  1  controller accepts request
sdr_busy_n  in  1  controller idle
sdr_wr_next  in  1  controller pops write word
sdr_wr_data  out  DW  muxed write data of granted requester
sdr_wr_en_n  out  DW/8  muxed byte enables of granted requester
sdr_rd_valid  in  1  read word valid
sdr_last_rd  in  1  last word of read burst
sdr_rd_data  in  DW  read data

Behaviour:
- Reset values: state IDLE, gnt=0, sdr_req=0, sdr_req_addr=0, sdr_req_len=0, sdr_req_wr_n=1, req_ack=0, beat counter=0, rr pointer=NREQ-1, so requester 0 wins first.
- States: IDLE, REQ, WR, RD.
- IDLE: when any req bit is 1 and sdr_busy_n=1:
  - Select the first set req searching from pointer+1 upward, wrapping modulo NREQ.
  - At the edge: gnt=one-hot(sel); pointer=sel; latch addr/len/wr_n into the sdr_req_* registers; sdr_req=1; state→REQ.
  - If sdr_busy_n=0, no grant is made.
- REQ: sdr_req and its fields stay stable until sdr_req_ack=1 is sampled.
  - In that same cycle, req_ack[sel]=1 combinationally. This is the requester's only acknowledge.
  - At the edge: sdr_req=0; beat counter=0; state→WR if wr_n=0, else RD.
  - If len=0, state→IDLE directly.
- WR: sdr_wr_data and sdr_wr_en_n are muxed from requester sel; an ungranted requester's data is never visible. req_wr_next[sel]=sdr_wr_next.
  - Each sdr_wr_next increments the counter.
  - The sdr_wr_next on which counter==len-1 ends the burst: state→IDLE, gnt=0.
  - sdr_rd_valid is ignored in WR.
- RD: req_rd_valid[sel]=sdr_rd_valid and req_last_rd[sel]=sdr_last_rd. req_rd_data=sdr_rd_data always.
  - sdr_rd_valid&sdr_last_rd → IDLE, gnt=0.
  - sdr_wr_next is ignored in RD.
- All req_* routed outputs are zero for non-granted requesters and in IDLE/REQ.
- Latency: grant is issued one edge after req is seen in IDLE. Minimum idle gap between bursts is one cycle (the IDLE cycle).
- A requester dropping req while in REQ does not cancel the request: the latched command is still issued and completed.
- Requests arriving during WR/RD wait. Fairness: a requester that was just served has lowest priority next round.
- Reset asserted in any state returns all registers to reset values at the next edge. In-flight controller traffic is not tracked.

Test Plan:
- Single write: req[0]=1, addr=0x000100, len=4, wr_n=0.
  → Grant 1 cycle later; sdr_req held until ack; req_ack[0] pulses once.
  → 4 sdr_wr_next pulses are routed to req_wr_next[0] with req_wr_data[0] on sdr_wr_data; IDLE after the 4th.
- Single read: req[1]=1, len=3, wr_n=1; controller returns 3 valid words, the last with sdr_last_rd.
  → Only req_rd_valid[1] pulses, 3 times; req_last_rd[1] on the 3rd; gnt→0.
- Round-robin: NREQ=2, req=2'b11 held continuously.
  → Grants alternate 0,1,0,1 over 4 bursts; first grant goes to 0 after reset.
- Back-pressure: sdr_busy_n=0 with req[0]=1 → no grant, sdr_req=0. Raising sdr_busy_n → grant the next cycle.
- Boundaries:
  - len=0 write → IDLE right after ack, no wr_next routed.
  - len=511 → counter completes exactly at the 511th pulse.
  - Requester drops req during REQ → burst still completes.
- Reset: assert sdram_resetn=0 mid-WR at beat 2 of 8 → next edge gnt=0, sdr_req=0, state IDLE, pointer=NREQ-1.
